// File: rtl/ram_port_master_if.sv
// ram_port_master_if: request/response handshake channels and the
// chip-select RAM port driven by ram_port_master.
//   req_*   : single-beat read/write request (valid/ready)
//   resp_*  : read data return (valid/ready)
//   wr_done : one-cycle pulse after a write strobe has been issued
//   mem_*   : RAM strobes, address, write data and registered read data
// Optional feature macro RAM_PORT_MASTER_CLR_EN adds clr_req, mem_clr, clr_done.
// modport master : the ram_port_master view
// modport slave  : the requester/RAM side view
interface ram_port_master_if #(
  parameter int AW = 5,
  parameter int DW = 8
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_data;
  logic          wr_done;
  logic          mem_cs;
  logic          mem_wrt;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
`ifdef RAM_PORT_MASTER_CLR_EN
  logic          clr_req;
  logic          mem_clr;
  logic          clr_done;
`endif

  modport master (
`ifdef RAM_PORT_MASTER_CLR_EN
    input  clr_req,
    output mem_clr, clr_done,
`endif
    input  req_valid, req_we, req_addr, req_wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_data, wr_done,
    output mem_cs, mem_wrt, mem_rd, mem_addr, mem_wdata
  );

  modport slave (
`ifdef RAM_PORT_MASTER_CLR_EN
    output clr_req,
    input  mem_clr, clr_done,
`endif
    output req_valid, req_we, req_addr, req_wdata, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_data, wr_done,
    input  mem_cs, mem_wrt, mem_rd, mem_addr, mem_wdata
  );
endinterface

// File: rtl/ram_port_master.sv
// ram_port_master: initiator for the chip-select RAM port (cs/wrt/rd).
// Accepts single-beat requests, sequences one RAM command per clock edge,
// captures the RAM's registered read data and returns it on a response
// channel. All outputs are registered.
// Ports:
//   clk  : clock, all logic on posedge
//   rst  : synchronous active-high reset
//   bus  : ram_port_master_if.master (request, response, wr_done, mem_*)
// Optional feature macro RAM_PORT_MASTER_CLR_EN: adds a one-cycle RAM
// clear command (clr_req -> CLR state driving mem_clr, then clr_done pulse).
module ram_port_master #(
  parameter int AW = 5,
  parameter int DW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  ram_port_master_if.master    bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_ISSUE = 3'd1,
    RD_ISSUE = 3'd2,
    RD_CAPT  = 3'd3,
    RESP     = 3'd4
`ifdef RAM_PORT_MASTER_CLR_EN
    ,
    CLR      = 3'd5
`endif
  } state_e;

  state_e        state_q, state_d;
  logic          req_ready_q, req_ready_d;
  logic          resp_valid_q, resp_valid_d;
  logic [DW-1:0] resp_data_q, resp_data_d;
  logic          wr_done_q, wr_done_d;
  logic          mem_cs_q, mem_cs_d;
  logic          mem_wrt_q, mem_wrt_d;
  logic          mem_rd_q, mem_rd_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
`ifdef RAM_PORT_MASTER_CLR_EN
  logic          mem_clr_q, mem_clr_d;
  logic          clr_done_q, clr_done_d;
  logic          clr_take;
`endif
  logic          accept;

`ifdef RAM_PORT_MASTER_CLR_EN
  // Clear has priority in IDLE, so a pending clear masks request acceptance.
  assign clr_take = (state_q == IDLE) && bus.clr_req;
  assign accept   = (state_q == IDLE) && bus.req_valid && req_ready_q && !bus.clr_req;
`else
  assign accept   = (state_q == IDLE) && bus.req_valid && req_ready_q;
`endif

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      wr_done_q    <= 1'b0;
      mem_cs_q     <= 1'b0;
      mem_wrt_q    <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
`ifdef RAM_PORT_MASTER_CLR_EN
      mem_clr_q    <= 1'b0;
      clr_done_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      wr_done_q    <= wr_done_d;
      mem_cs_q     <= mem_cs_d;
      mem_wrt_q    <= mem_wrt_d;
      mem_rd_q     <= mem_rd_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
`ifdef RAM_PORT_MASTER_CLR_EN
      mem_clr_q    <= mem_clr_d;
      clr_done_q   <= clr_done_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
`ifdef RAM_PORT_MASTER_CLR_EN
        if (clr_take) state_d = CLR;
        else
`endif
        if (accept) state_d = bus.req_we ? WR_ISSUE : RD_ISSUE;
      end
      WR_ISSUE: state_d = IDLE;
      RD_ISSUE: state_d = RD_CAPT;
      RD_CAPT:  state_d = RESP;
      RESP:     if (bus.resp_ready) state_d = IDLE;
`ifdef RAM_PORT_MASTER_CLR_EN
      CLR:      state_d = IDLE;
`endif
      default:  state_d = IDLE;
    endcase
  end

  // Output logic: outputs are registered, so the strobes for the cycle
  // following an edge are decoded from the state entered at that edge.
  always_comb begin
    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
    wr_done_d    = (state_q == WR_ISSUE);
    mem_wrt_d    = (state_d == WR_ISSUE);
    mem_rd_d     = (state_d == RD_ISSUE) || (state_d == RD_CAPT);
    mem_cs_d     = mem_wrt_d || mem_rd_d;
    resp_data_d  = resp_data_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
`ifdef RAM_PORT_MASTER_CLR_EN
    mem_clr_d    = (state_d == CLR);
    clr_done_d   = (state_q == CLR);
    mem_cs_d     = mem_wrt_d || mem_rd_d || mem_clr_d;
`endif
    // RAM word registered at the RD_ISSUE edge is on mem_rdata during RD_CAPT.
    if (state_q == RD_CAPT) resp_data_d = bus.mem_rdata;
    if (accept) begin
      mem_addr_d  = bus.req_addr;
      mem_wdata_d = bus.req_wdata;
    end
  end

`ifdef RAM_PORT_MASTER_CLR_EN
  // clr_req must block acceptance in the same cycle, so it gates the flop.
  assign bus.req_ready = req_ready_q && !bus.clr_req;
  assign bus.mem_clr   = mem_clr_q;
  assign bus.clr_done  = clr_done_q;
`else
  assign bus.req_ready = req_ready_q;
`endif
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.wr_done    = wr_done_q;
  assign bus.mem_cs     = mem_cs_q;
  assign bus.mem_wrt    = mem_wrt_q;
  assign bus.mem_rd     = mem_rd_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_ram_port_master.sv
// Directed self-checking bench for ram_port_master with a 32x8 RAM model
// (registered read, write on cs&wrt, clear on cs&mem_clr when enabled).
module tb_ram_port_master;
  localparam int AW = 5;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_port_master_if #(.AW(AW), .DW(DW)) bus();
  ram_port_master #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [DW-1:0] ram [0:31];
  always @(posedge clk) begin
    if (bus.mem_cs && bus.mem_wrt) ram[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_cs && bus.mem_rd)  bus.mem_rdata <= ram[bus.mem_addr];
`ifdef RAM_PORT_MASTER_CLR_EN
    if (bus.mem_cs && bus.mem_clr) for (int i = 0; i < 32; i++) ram[i] <= '0;
`endif
  end

  int total = 0;
  int bad   = 0;
  int viol  = 0;

  always @(negedge clk)
    if (!rst && ((bus.mem_wrt && bus.mem_rd) || ((bus.mem_wrt || bus.mem_rd) && !bus.mem_cs)))
      viol++;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Plain read with bounded wait; caller checks data and latency.
  task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output int lat);
    bus.resp_ready = 1'b1;
    bus.req_we = 1'b0; bus.req_addr = a; bus.req_valid = 1'b1;
    tick;
    bus.req_valid = 1'b0;
    lat = 0;
    while (!bus.resp_valid && lat < 10) begin tick; lat++; end
    d = bus.resp_data;
    tick;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick; tick;
    total++;
    if ({bus.req_ready, bus.resp_valid, bus.wr_done, bus.mem_cs, bus.mem_wrt, bus.mem_rd} !== 6'b100000) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=100000",
        {bus.req_ready, bus.resp_valid, bus.wr_done, bus.mem_cs, bus.mem_wrt, bus.mem_rd});
    end
    total++;
    if ({bus.resp_data, bus.mem_addr, bus.mem_wdata} !== 21'h0) begin
      bad++; $display("FAIL reset_data got=%h exp=0", {bus.resp_data, bus.mem_addr, bus.mem_wdata});
    end
`ifdef RAM_PORT_MASTER_CLR_EN
    total++;
    if ({bus.mem_clr, bus.clr_done} !== 2'b00) begin
      bad++; $display("FAIL reset_clr got=%b exp=00", {bus.mem_clr, bus.clr_done});
    end
`endif
    rst = 1'b0;
    tick;
  endtask

  task automatic test_writes;
    logic [AW-1:0] wa [3];
    logic [DW-1:0] wd [3];
    wa[0] = 5'h1B; wd[0] = 8'h24;
    wa[1] = 5'h0A; wd[1] = 8'h36;
    wa[2] = 5'h1B; wd[2] = 8'h68;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (bus.req_ready !== 1'b1) begin
        bad++; $display("FAIL wr_idle_ready[%0d] got=%b exp=1", i, bus.req_ready);
      end
      bus.req_we = 1'b1; bus.req_addr = wa[i]; bus.req_wdata = wd[i]; bus.req_valid = 1'b1;
      tick;
      bus.req_valid = 1'b0;
      total++;
      if ({bus.mem_cs, bus.mem_wrt, bus.mem_rd, bus.req_ready, bus.wr_done} !== 5'b11000) begin
        bad++; $display("FAIL wr_issue[%0d] got=%b exp=11000", i,
          {bus.mem_cs, bus.mem_wrt, bus.mem_rd, bus.req_ready, bus.wr_done});
      end
      total++;
      if ({bus.mem_addr, bus.mem_wdata} !== {wa[i], wd[i]}) begin
        bad++; $display("FAIL wr_addr_data[%0d] got=%h exp=%h", i, {bus.mem_addr, bus.mem_wdata}, {wa[i], wd[i]});
      end
      tick;
      total++;
      if ({bus.mem_cs, bus.mem_wrt, bus.mem_rd, bus.req_ready, bus.wr_done} !== 5'b00011) begin
        bad++; $display("FAIL wr_done[%0d] got=%b exp=00011", i,
          {bus.mem_cs, bus.mem_wrt, bus.mem_rd, bus.req_ready, bus.wr_done});
      end
      tick;
      total++;
      if ({bus.mem_cs, bus.wr_done, bus.req_ready} !== 3'b001) begin
        bad++; $display("FAIL wr_done_end[%0d] got=%b exp=001", i, {bus.mem_cs, bus.wr_done, bus.req_ready});
      end
    end
  endtask

  task automatic test_reads;
    logic [AW-1:0] ra [2];
    logic [DW-1:0] rd [2];
    ra[0] = 5'h0A; rd[0] = 8'h36;
    ra[1] = 5'h1B; rd[1] = 8'h68;
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.req_we = 1'b0; bus.req_addr = ra[i]; bus.req_valid = 1'b1;
      tick;
      bus.req_valid = 1'b0;
      total++;
      if ({bus.mem_cs, bus.mem_wrt, bus.mem_rd, bus.req_ready, bus.resp_valid, bus.mem_addr} !== {5'b10100, ra[i]}) begin
        bad++; $display("FAIL rd_issue[%0d] got=%h exp=%h", i,
          {bus.mem_cs, bus.mem_wrt, bus.mem_rd, bus.req_ready, bus.resp_valid, bus.mem_addr}, {5'b10100, ra[i]});
      end
      tick;
      total++;
      if ({bus.mem_cs, bus.mem_wrt, bus.mem_rd, bus.req_ready, bus.resp_valid} !== 5'b10100) begin
        bad++; $display("FAIL rd_capt[%0d] got=%b exp=10100", i,
          {bus.mem_cs, bus.mem_wrt, bus.mem_rd, bus.req_ready, bus.resp_valid});
      end
      tick;
      total++;
      if ({bus.mem_cs, bus.mem_rd, bus.req_ready, bus.resp_valid, bus.resp_data} !== {4'b0001, rd[i]}) begin
        bad++; $display("FAIL rd_resp[%0d] got=%h exp=%h", i,
          {bus.mem_cs, bus.mem_rd, bus.req_ready, bus.resp_valid, bus.resp_data}, {4'b0001, rd[i]});
      end
      tick;
      total++;
      if ({bus.resp_valid, bus.req_ready} !== 2'b01) begin
        bad++; $display("FAIL rd_consumed[%0d] got=%b exp=01", i, {bus.resp_valid, bus.req_ready});
      end
    end
  endtask

  task automatic test_backpressure;
    bus.resp_ready = 1'b0;
    bus.req_we = 1'b0; bus.req_addr = 5'h0A; bus.req_valid = 1'b1;
    tick;
    bus.req_addr = 5'h1B;  // next request held pending while busy
    tick; tick;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({bus.resp_valid, bus.req_ready, bus.mem_cs, bus.mem_rd, bus.resp_data, bus.mem_addr} !== {4'b1000, 8'h36, 5'h0A}) begin
        bad++; $display("FAIL bp_hold[%0d] got=%h exp=%h", i,
          {bus.resp_valid, bus.req_ready, bus.mem_cs, bus.mem_rd, bus.resp_data, bus.mem_addr}, {4'b1000, 8'h36, 5'h0A});
      end
      tick;
    end
    bus.resp_ready = 1'b1;
    tick;
    total++;
    if ({bus.resp_valid, bus.req_ready, bus.mem_cs} !== 3'b010) begin
      bad++; $display("FAIL bp_idle got=%b exp=010", {bus.resp_valid, bus.req_ready, bus.mem_cs});
    end
    tick;
    bus.req_valid = 1'b0;
    total++;
    if ({bus.mem_cs, bus.mem_rd, bus.req_ready, bus.mem_addr} !== {3'b110, 5'h1B}) begin
      bad++; $display("FAIL bp_held_accept got=%h exp=%h", {bus.mem_cs, bus.mem_rd, bus.req_ready, bus.mem_addr}, {3'b110, 5'h1B});
    end
    tick; tick;
    total++;
    if ({bus.resp_valid, bus.resp_data} !== {1'b1, 8'h68}) begin
      bad++; $display("FAIL bp_second_read got=%h exp=%h", {bus.resp_valid, bus.resp_data}, {1'b1, 8'h68});
    end
    tick;
  endtask

  task automatic test_reset_mid;
    logic [DW-1:0] d;
    int lat;
    bus.resp_ready = 1'b1;
    bus.req_we = 1'b0; bus.req_addr = 5'h0A; bus.req_valid = 1'b1;
    tick;
    bus.req_valid = 1'b0;
    tick;  // now in RD_CAPT
    rst = 1'b1;
    tick;
    rst = 1'b0;
    total++;
    if ({bus.req_ready, bus.resp_valid, bus.wr_done, bus.mem_cs, bus.mem_wrt, bus.mem_rd, bus.resp_data, bus.mem_addr, bus.mem_wdata}
        !== {6'b100000, 21'h0}) begin
      bad++; $display("FAIL rstmid_outputs got=%h exp=%h",
        {bus.req_ready, bus.resp_valid, bus.wr_done, bus.mem_cs, bus.mem_wrt, bus.mem_rd, bus.resp_data, bus.mem_addr, bus.mem_wdata},
        {6'b100000, 21'h0});
    end
    tick;
    total++;
    if (bus.resp_valid !== 1'b0) begin
      bad++; $display("FAIL rstmid_no_resp got=%b exp=0", bus.resp_valid);
    end
    // write request accepted on an edge where rst is high must not be issued
    bus.req_we = 1'b1; bus.req_addr = 5'h0A; bus.req_wdata = 8'h55; bus.req_valid = 1'b1;
    rst = 1'b1;
    tick;
    bus.req_valid = 1'b0;
    rst = 1'b0;
    total++;
    if ({bus.mem_cs, bus.mem_wrt, bus.req_ready} !== 3'b001) begin
      bad++; $display("FAIL rst_write_blocked got=%b exp=001", {bus.mem_cs, bus.mem_wrt, bus.req_ready});
    end
    tick;
    do_read(5'h1B, d, lat);
    total++;
    if ({d, lat[3:0]} !== {8'h68, 4'd2}) begin
      bad++; $display("FAIL rst_then_read got=%h lat=%0d exp=68 lat=2", d, lat);
    end
    do_read(5'h0A, d, lat);
    total++;
    if (d !== 8'h36) begin
      bad++; $display("FAIL rst_write_not_done got=%h exp=36", d);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    bus.resp_ready = 1'b1;
    bus.req_we = 1'b1; bus.req_addr = 5'h1F; bus.req_wdata = 8'hFF; bus.req_valid = 1'b1;
    tick;
    bus.req_we = 1'b0;  // read of the same all-ones address, req_valid held
    tick;
    total++;
    if ({bus.wr_done, bus.req_ready, bus.mem_wrt} !== 3'b110) begin
      bad++; $display("FAIL b2b_wr_done got=%b exp=110", {bus.wr_done, bus.req_ready, bus.mem_wrt});
    end
    tick;
    bus.req_valid = 1'b0;
    total++;
    if ({bus.mem_rd, bus.mem_addr} !== {1'b1, 5'h1F}) begin
      bad++; $display("FAIL b2b_rd_issue got=%h exp=%h", {bus.mem_rd, bus.mem_addr}, {1'b1, 5'h1F});
    end
    n = 0;
    while (!bus.resp_valid && n < 10) begin tick; n++; end
    total++;
    if ({bus.resp_valid, bus.resp_data, n[3:0]} !== {1'b1, 8'hFF, 4'd2}) begin
      bad++; $display("FAIL b2b_read got=%h n=%0d exp=1ff n=2", {bus.resp_valid, bus.resp_data}, n);
    end
    tick;
    total++;
    if (viol !== 0) begin
      bad++; $display("FAIL strobe_rules got=%0d violations exp=0", viol);
    end
  endtask

`ifdef RAM_PORT_MASTER_CLR_EN
  task automatic test_clr;
    int n;
    bus.resp_ready = 1'b1;
    bus.clr_req = 1'b1;
    bus.req_we = 1'b0; bus.req_addr = 5'h1B; bus.req_valid = 1'b1;
    #1;
    total++;
    if (bus.req_ready !== 1'b0) begin
      bad++; $display("FAIL clr_masks_ready got=%b exp=0", bus.req_ready);
    end
    tick;
    bus.clr_req = 1'b0;
    total++;
    if ({bus.mem_cs, bus.mem_clr, bus.mem_wrt, bus.mem_rd, bus.req_ready, bus.clr_done} !== 6'b110000) begin
      bad++; $display("FAIL clr_issue got=%b exp=110000",
        {bus.mem_cs, bus.mem_clr, bus.mem_wrt, bus.mem_rd, bus.req_ready, bus.clr_done});
    end
    tick;
    total++;
    if ({bus.mem_cs, bus.mem_clr, bus.clr_done, bus.req_ready} !== 4'b0011) begin
      bad++; $display("FAIL clr_done got=%b exp=0011", {bus.mem_cs, bus.mem_clr, bus.clr_done, bus.req_ready});
    end
    tick;
    bus.req_valid = 1'b0;
    total++;
    if ({bus.clr_done, bus.mem_rd, bus.mem_addr} !== {2'b01, 5'h1B}) begin
      bad++; $display("FAIL clr_then_accept got=%h exp=%h", {bus.clr_done, bus.mem_rd, bus.mem_addr}, {2'b01, 5'h1B});
    end
    n = 0;
    while (!bus.resp_valid && n < 10) begin tick; n++; end
    total++;
    if ({bus.resp_valid, bus.resp_data} !== {1'b1, 8'h00}) begin
      bad++; $display("FAIL clr_read got=%h exp=100", {bus.resp_valid, bus.resp_data});
    end
    tick;
  endtask
`endif

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b1;
`ifdef RAM_PORT_MASTER_CLR_EN
    bus.clr_req    = 1'b0;
`endif
    test_reset;
    test_writes;
    test_reads;
    test_backpressure;
    test_reset_mid;
    test_back_to_back;
`ifdef RAM_PORT_MASTER_CLR_EN
    test_clr;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
